// File: rtl/icb_sram_ctrl_pkg.sv
// icb_sram_ctrl_pkg: shared ICB field widths, default region bases, clogb2 and response FSM states.
// No ports; imported by the interface, the byte bank and the controller top.
package icb_sram_ctrl_pkg;
   localparam int ICB_ADDR_W = 32;
   localparam logic [ICB_ADDR_W-1:0] MEM_BASE_DEF = 32'h2000_0000;
   localparam logic [ICB_ADDR_W-1:0] IO_BASE_DEF = 32'h2001_0000;
   typedef enum logic {IDLE, RSP} rsp_state_e;
   function automatic int clogb2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/icb_sram_ctrl_if.sv
// icb_sram_ctrl_if: ICB command/response channel bundle.
// cmd_*: valid/ready command with byte address, read flag, write data and byte mask.
// rsp_*: valid/ready response with error flag and read data.
// modport master drives commands; modport slave answers them.
interface icb_sram_ctrl_if import icb_sram_ctrl_pkg::*; #(parameter int DATA_W = 32) ();
   localparam int NB = DATA_W / 8;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ICB_ADDR_W-1:0] cmd_addr;
   logic                  cmd_read;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [NB-1:0]         cmd_wmask;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_err;
   logic [DATA_W-1:0]     rsp_rdata;
   modport master (output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
                   input cmd_ready, rsp_valid, rsp_err, rsp_rdata);
   modport slave (input cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

// File: rtl/icb_sram_ctrl_sram_byte_bank.sv
// sram_byte_bank: one 8-bit x DEPTH synchronous RAM lane, read-first, output register updates only when en.
// Ports: clk; en (access strobe); we (write this lane); addr (word index); wdata; rdata (registered old word).
module sram_byte_bank #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/icb_sram_ctrl.sv
// icb_sram_ctrl: ICB slave SRAM controller with a window of synchronised 8-bit input ports.
// Ports: clk; rst_n (async, active low); in_port (N_IN asynchronous byte ports);
//        icb (slave side of the ICB command/response channel).
module icb_sram_ctrl import icb_sram_ctrl_pkg::*; #(
   parameter int          DATA_W   = 32,
   parameter int          DEPTH    = 4096,
   parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
   parameter logic [31:0] IO_BASE  = IO_BASE_DEF,
   parameter int          N_IN     = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [8*N_IN-1:0] in_port,
   icb_sram_ctrl_if.slave    icb
);
   localparam int NB = DATA_W / 8;
   localparam int OB = clogb2(NB);
   localparam int AW = clogb2(DEPTH);
   localparam logic [31:0] MEM_SPAN = 32'(DEPTH * NB);
   localparam logic [31:0] IO_SPAN  = 32'(N_IN * NB);

   logic [8*N_IN-1:0] sync1, sync2;
   logic [31:0]       mem_off, io_off;
   logic              mis, mem_hit, io_hit, io_rd, acc, bank_en;
   logic [7:0]        io_byte;
   logic [DATA_W-1:0] bank_q, dat_q;
   logic              err_q, sel_mem_q;
   rsp_state_e        state_q, state_d;

   assign acc           = icb.cmd_valid & icb.cmd_ready;
   assign icb.cmd_ready = ~icb.rsp_valid | icb.rsp_ready;
   // Offsets wrap below the base, so a single unsigned compare covers both bounds.
   assign mem_off = icb.cmd_addr - MEM_BASE;
   assign io_off  = icb.cmd_addr - IO_BASE;
   assign mis     = |icb.cmd_addr[OB-1:0];
   assign mem_hit = ~mis & (mem_off < MEM_SPAN);
   assign io_hit  = ~mis & (io_off < IO_SPAN);
   assign io_rd   = io_hit & icb.cmd_read;
   assign bank_en = acc & mem_hit;

   always_comb begin
      io_byte = '0;
      for (int k = 0; k < N_IN; k++)
         if ((io_off >> OB) == 32'(k)) io_byte = sync2[8*k +: 8];
   end

   for (genvar b = 0; b < NB; b++) begin : g_lane
      sram_byte_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
         .clk   (clk),
         .en    (bank_en),
         .we    (~icb.cmd_read & icb.cmd_wmask[b]),
         .addr  (icb.cmd_addr[OB +: AW]),
         .wdata (icb.cmd_wdata[8*b +: 8]),
         .rdata (bank_q[8*b +: 8])
      );
   end

   // Memory reads come straight from the lane output registers; everything else is captured in dat_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '0;
         sync2     <= '0;
         state_q   <= IDLE;
         err_q     <= 1'b0;
         sel_mem_q <= 1'b0;
         dat_q     <= '0;
      end else begin
         sync1   <= in_port;
         sync2   <= sync1;
         state_q <= state_d;
         if (acc) begin
            err_q     <= ~(mem_hit | io_rd);
            sel_mem_q <= mem_hit & icb.cmd_read;
            dat_q     <= io_rd ? DATA_W'(io_byte) : '0;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      icb.rsp_valid = state_q == RSP;
      icb.rsp_err   = err_q;
      icb.rsp_rdata = sel_mem_q ? bank_q : dat_q;
      if (acc) state_d = RSP;
      else if (state_q == RSP && icb.rsp_ready) state_d = IDLE;
   end
endmodule
